// File: rtl/cp0_timer_irq_pkg.sv
// rtl/cp0_timer_irq_pkg.sv - CP0 register ids, interrupt vector type and shared pending-interrupt function
package cp0_timer_irq_pkg;

  localparam logic [4:0] CP0_COUNT_ID   = 5'd9;
  localparam logic [4:0] CP0_COMPARE_ID = 5'd11;

  typedef logic [5:0] hwint_t;

  // Shared with the exception unit so both agree on when an interrupt is taken.
  function automatic logic irq_pending(
    input logic [7:0] ip,
    input logic [7:0] im,
    input logic       ie,
    input logic       exl,
    input logic       erl
  );
    return ie & ~exl & ~erl & (|(ip & im));
  endfunction

endpackage

// File: rtl/cp0_timer_irq_if.sv
// rtl/cp0_timer_irq_if.sv - mtc0 write bus forwarded from cp0 to the timer/interrupt block
interface cp0_timer_irq_if;

  logic        wr_valid;
  logic [4:0]  wr_id;
  logic [31:0] wr_data;

  modport master (output wr_valid, output wr_id, output wr_data);
  modport slave  (input  wr_valid, input  wr_id, input  wr_data);

endinterface

// File: rtl/cp0_timer_irq_irq_sync.sv
// rtl/cp0_timer_irq_irq_sync.sv - N-bit multi-stage synchroniser for asynchronous interrupt lines
module irq_sync #(
  parameter int N      = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/cp0_timer_irq.sv
// rtl/cp0_timer_irq.sv - Count/Compare timer, Cause.TI and hardware interrupt request logic
module cp0_timer_irq
  import cp0_timer_irq_pkg::*;
#(
  parameter int COUNT_DIV   = 2,
  parameter int N_HWINT     = 6,
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_LINE  = 5
) (
  input  logic               clk,
  input  logic               resetn,
  cp0_timer_irq_if.slave     wr,
  input  logic [N_HWINT-1:0] ext_int,
  input  logic               status_ie,
  input  logic               status_exl,
  input  logic               status_erl,
  input  logic [7:0]         status_im,
  input  logic [1:0]         cause_ip_sw,
  output logic [31:0]        count,
  output logic [31:0]        compare,
  output logic               cause_ti,
  output hwint_t             cause_ip_hw,
  output logic               int_req
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic         count_wr;
  logic         compare_wr;
  logic         tick;
  logic         count_upd;
  logic [31:0]  count_nxt;
  logic         match;
  logic [N_HWINT-1:0] sync_q;
  hwint_t       ip_hw;

  assign count_wr   = wr.wr_valid && (wr.wr_id == CP0_COUNT_ID);
  assign compare_wr = wr.wr_valid && (wr.wr_id == CP0_COMPARE_ID);

  // A Count write restarts the prescaler so the next increment is a full period away.
  generate
    if (COUNT_DIV > 1) begin : g_presc
      logic [PW-1:0] presc;

      assign tick = (presc == PW'(COUNT_DIV - 1));

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          presc <= '0;
        end else if (count_wr || tick) begin
          presc <= '0;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end else begin : g_no_presc
      assign tick = 1'b1;
    end
  endgenerate

  assign count_upd = count_wr | tick;
  assign count_nxt = count_wr ? wr.wr_data : (count + 32'd1);
  // Compared against the Compare value held before this edge, so a fresh write never matches itself.
  assign match     = count_upd && (count_nxt == compare);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count    <= '0;
      compare  <= '0;
      cause_ti <= 1'b0;
    end else begin
      if (count_upd) begin
        count <= count_nxt;
      end
      if (compare_wr) begin
        compare  <= wr.wr_data;
        cause_ti <= 1'b0;
      end else if (match) begin
        cause_ti <= 1'b1;
      end
    end
  end

  irq_sync #(
    .N      (N_HWINT),
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (ext_int),
    .q      (sync_q)
  );

  always_comb begin
    ip_hw                 = '0;
    ip_hw[N_HWINT-1:0]    = sync_q;
    ip_hw[TIMER_LINE]     = ip_hw[TIMER_LINE] | cause_ti;
  end

  assign cause_ip_hw = ip_hw;

  // Gated by resetn so a held software interrupt cannot raise a request while in reset.
  assign int_req = resetn & irq_pending({ip_hw, cause_ip_sw}, status_im,
                                        status_ie, status_exl, status_erl);

endmodule

// File: doc/cp0_timer_irq.md
Name: cp0_timer_irq

Overview:
- Parametrised successor to the CP0 Count/Compare/interrupt logic.
- Owns Count, Compare, the timer-interrupt flag (Cause.TI) and synchronisation of external hardware interrupt lines.
- Produces Cause.IP[7:2] and a masked interrupt request, which the exception unit consumes.
- Sits beside cp0; cp0 forwards mtc0 writes to it and muxes its Count and Compare values into mfc0 reads.

Parameters:
- COUNT_DIV, default 2: Count increments once every COUNT_DIV clocks; legal range 1..16.
- N_HWINT, default 6: number of external interrupt lines; legal range 1..6; drive Cause.IP[2 +: N_HWINT].
- SYNC_STAGES, default 2: flop stages on each external line; legal range 1..4.
- TIMER_LINE, default 5: hardware line (0..5) that TI is ORed onto, i.e. IP[2+TIMER_LINE].

Ports:
- clk, in, 1: clock.
- resetn, in, 1: asynchronous active-low reset.
- wr_valid, in, 1: mtc0 write strobe, one cycle.
- wr_id, in, 5: CP0 register number of the write.
- wr_data, in, 32: write data.
- ext_int, in, N_HWINT: asynchronous level-sensitive hardware interrupts.
- status_ie, in, 1: Status.IE.
- status_exl, in, 1: Status.EXL.
- status_erl, in, 1: Status.ERL.
- status_im, in, 8: Status.IM.
- cause_ip_sw, in, 2: Cause.IP[1:0], the software interrupts held in cp0.
- count, out, 32: Count register.
- compare, out, 32: Compare register.
- cause_ti, out, 1: Cause.TI.
- cause_ip_hw, out, 6: Cause.IP[7:2].
- int_req, out, 1: pending, unmasked, enabled interrupt.

Behaviour:
- Reset (asynchronous, resetn=0):
  - count=0, compare=0, cause_ti=0, prescaler=0, all sync flops=0.
  - cause_ip_hw=0, int_req=0.
  - Outputs hold these values for as long as resetn is low, including when reset is asserted mid-operation.
- Prescaler:
  - Counter of width clog2(COUNT_DIV), or none when COUNT_DIV=1.
  - tick=1 when prescaler==COUNT_DIV-1; prescaler then wraps to 0.
  - Count += 1 (mod 2^32) on each tick.
  - 0xFFFFFFFF wraps to 0 with no side effect.
- Write to Count (wr_valid & wr_id==9):
  - count<=wr_data and prescaler<=0 in that same edge; that edge's tick increment is discarded.
  - The next increment follows COUNT_DIV clocks later.
- Write to Compare (wr_valid & wr_id==11):
  - compare<=wr_data and cause_ti<=0.
  - All other wr_id values are ignored.
- Timer match:
  - match = the value Count takes this edge equals compare, and that value was produced by a tick increment or a Count write.
  - cause_ti<=1 on a match; TI is sticky until the next Compare write.
  - A Compare value of 0 is a legal match target.
  - Reset state (count=0, compare=0) does not fire, because no update has occurred.
- Simultaneous events:
  - Compare write and a match on the same edge: the write wins, so TI=0.
  - A match against the newly written Compare value takes effect only from the next Count update.
- External interrupts:
  - Each line passes through SYNC_STAGES flops; latency is SYNC_STAGES clocks from the ext_int edge to cause_ip_hw.
  - Lines are level-sensitive and not latched; deassertion propagates with the same latency.
- cause_ip_hw[i] = sync[i] for i<N_HWINT, else 0.
- Bit TIMER_LINE is additionally ORed with cause_ti.
- int_req (combinational from registered state and status inputs):
  - int_req = status_ie & ~status_exl & ~status_erl & |({cause_ip_hw, cause_ip_sw} & status_im).
- count, compare and cause_ti are direct register outputs with zero read latency.

Decomposition:
- cp0_pkg gains the following:
  - localparams CP0_COUNT_ID=5'd9 and CP0_COMPARE_ID=5'd11.
  - Typedef hwint_t (6-bit vector).
  - A function irq_pending(ip, im, ie, exl, erl) shared with the exception logic.
- Sub-module irq_sync: one N-bit, SYNC_STAGES-deep synchroniser with asynchronous active-low reset.
- Prescaler and timer logic stay inline.

Test Plan:
- COUNT_DIV=2, reset released, no writes -> count=0,0,1,1,2 on successive clocks; cause_ti stays 0 through cycle 10.
- Write compare=5, run -> cause_ti rises on the edge where count becomes 5 and holds.
  - With IM[7]=1, IE=1, EXL=0: int_req=1.
  - Then write compare=9 -> cause_ti=0 next cycle.
- Write count=0xFFFFFFFE with COUNT_DIV=1 -> count reads FFFFFFFF, then 00000000; with compare=0, cause_ti=1 on the wrap.
- Compare write coincident with a match edge -> cause_ti=0 afterwards.
  - Count write of the compare value -> cause_ti=1 on the next edge.
- SYNC_STAGES=2: ext_int[0] rises -> cause_ip_hw[0]=1 exactly 2 clocks later.
  - int_req=1 only when IM[2]=1.
  - EXL=1 or ERL=1 forces int_req=0.
- Assert resetn low mid-count (count=37, cause_ti=1) -> all outputs read 0 asynchronously before the next clk edge.
